// File: rtl/lgc_pkg.sv
// Shared types and constants for the loop-gain lock-in correlator.
// quarter_sin builds the sine ROM contents when the design is elaborated, using integer Taylor series.
package lgc_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} lgc_state_t;

   localparam int     LUT_AW    = 10;
   localparam int     LUT_AMP   = 2047;
   localparam int     DRAIN_CYC = 3;
   localparam int     QTR       = 2 ** (LUT_AW - 2);
   localparam longint PI_Q30    = 64'sd3373259426;

   // round(LUT_AMP * sin(pi/2 * k/QTR)) for k in [0, QTR], in Q30 fixed point
   function automatic int quarter_sin(input int k);
      longint x;
      longint x2;
      longint term;
      longint sum;
      x    = (longint'(k) * PI_Q30) / longint'(2 * QTR);
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int n = 1; n <= 10; n++) begin
         term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
         sum  = sum + term;
      end
      return int'((sum * longint'(LUT_AMP) + (64'sd1 <<< 29)) >>> 30);
   endfunction

endpackage

// File: rtl/lgc_sincos_lut.sv
// Quarter-wave sine ROM with quadrant folding; registered sin and cos, one cycle of latency.
module lgc_sincos_lut
   import lgc_pkg::*;
#(
   parameter int COS_W = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_en,
   input  logic [LUT_AW-1:0]       i_idx,
   output logic signed [COS_W-1:0] o_sin,
   output logic signed [COS_W-1:0] o_cos
);

   localparam int MAG_W = COS_W - 1;
   localparam int QIX_W = LUT_AW - 1;

   logic [MAG_W-1:0]        w_rom [0:QTR];
   logic [LUT_AW-1:0]       w_cos_idx;
   logic [QIX_W:0]          w_sf;
   logic [QIX_W:0]          w_cf;
   logic signed [COS_W-1:0] w_sin;
   logic signed [COS_W-1:0] w_cos;

   for (genvar k = 0; k <= QTR; k++) begin : g_rom
      localparam int V = quarter_sin(k);
      assign w_rom[k] = MAG_W'(V);
   end

   // {negate, quarter-table index}; odd quadrants read the table mirrored
   function automatic logic [QIX_W:0] fold(input logic [LUT_AW-1:0] p);
      logic [QIX_W-1:0] ix;
      if (p[LUT_AW-2]) ix = QIX_W'(QTR) - QIX_W'(p[LUT_AW-3:0]);
      else             ix = QIX_W'(p[LUT_AW-3:0]);
      return {p[LUT_AW-1], ix};
   endfunction

   always_comb begin
      w_cos_idx = i_idx + LUT_AW'(QTR);
      w_sf      = fold(i_idx);
      w_cf      = fold(w_cos_idx);
      w_sin     = signed'({1'b0, w_rom[w_sf[QIX_W-1:0]]});
      w_cos     = signed'({1'b0, w_rom[w_cf[QIX_W-1:0]]});
      if (w_sf[QIX_W]) w_sin = -w_sin;
      if (w_cf[QIX_W]) w_cos = -w_cos;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_sin <= '0;
         o_cos <= '0;
      end else if (i_en) begin
         o_sin <= w_sin;
         o_cos <= w_cos;
      end
   end

endmodule

// File: rtl/loop_gain_correlator.sv
// Lock-in receiver: correlates injection and response samples against an NCO cos/sin
// and returns saturating I/Q sums for both channels.
//   state | meaning
//   IDLE  | waiting for start; last result stays on the ports
//   ACCUM | accepting n_samples strobed samples
//   DRAIN | flushing the 3-stage LUT/multiply/accumulate pipeline
//   HOLD  | result valid, waiting for r_ready
module loop_gain_correlator
   import lgc_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int PHASE_W = 24,
   parameter int COS_W   = 12,
   parameter int CNT_W   = 16,
   parameter int ACC_W   = 48
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_start,
   input  logic [PHASE_W-1:0]       i_ftw,
   input  logic [CNT_W-1:0]         i_n_samples,
   input  logic                     i_s_valid,
   input  logic signed [DATA_W-1:0] i_s_in,
   input  logic signed [DATA_W-1:0] i_s_out,
   output logic                     o_busy,
   output logic                     o_r_valid,
   input  logic                     i_r_ready,
   output logic signed [ACC_W-1:0]  o_r_in_i,
   output logic signed [ACC_W-1:0]  o_r_in_q,
   output logic signed [ACC_W-1:0]  o_r_out_i,
   output logic signed [ACC_W-1:0]  o_r_out_q,
   output logic                     o_overflow
);

   localparam int PROD_W = DATA_W + COS_W;
   localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
   localparam int DRN_W  = $clog2(DRAIN_CYC);
   localparam logic signed [SUM_W-1:0] SAT_HI = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_LO = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

   lgc_state_t              r_state;
   lgc_state_t              w_state_nxt;
   logic [PHASE_W-1:0]      r_ftw;
   logic [PHASE_W-1:0]      r_phase;
   logic [CNT_W-1:0]        r_n;
   logic [CNT_W-1:0]        r_count;
   logic [DRN_W-1:0]        r_drain;
   logic                    w_launch;
   logic                    w_accept;
   logic                    w_last;
   logic signed [COS_W-1:0] w_sin;
   logic signed [COS_W-1:0] w_cos;
   logic signed [DATA_W-1:0] r_x_in;
   logic signed [DATA_W-1:0] r_x_out;
   logic                    r_v1;
   logic                    r_v2;
   logic signed [PROD_W-1:0] r_prod [4];
   logic signed [ACC_W-1:0] r_acc [4];
   logic [ACC_W:0]          w_sat [4];
   logic                    r_ovf;

   // {saturated, sum} clamped to the ACC_W two's complement range
   function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0]  a,
                                              input logic signed [PROD_W-1:0] b);
      logic signed [SUM_W-1:0] s;
      s = SUM_W'(a) + SUM_W'(b);
      if (s > SAT_HI) return {1'b1, SAT_HI[ACC_W-1:0]};
      if (s < SAT_LO) return {1'b1, SAT_LO[ACC_W-1:0]};
      return {1'b0, s[ACC_W-1:0]};
   endfunction

   assign w_launch = (r_state == IDLE) && i_start && (i_n_samples != '0);
   assign w_accept = (r_state == ACCUM) && i_s_valid;
   assign w_last   = (r_count == r_n - CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_busy      = (r_state != IDLE);
      o_r_valid   = (r_state == HOLD);
      unique case (r_state)
         IDLE:    if (w_launch) w_state_nxt = ACCUM;
         ACCUM:   if (w_accept && w_last) w_state_nxt = DRAIN;
         DRAIN:   if (r_drain == '0) w_state_nxt = HOLD;
         HOLD:    if (i_r_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ftw   <= '0;
         r_n     <= '0;
         r_phase <= '0;
         r_count <= '0;
         r_drain <= '0;
      end else begin
         if (w_launch) begin
            r_ftw   <= i_ftw;
            r_n     <= i_n_samples;
            r_phase <= '0;
            r_count <= '0;
         end else if (w_accept) begin
            r_phase <= r_phase + r_ftw;
            r_count <= r_count + CNT_W'(1);
         end
         if (w_accept && w_last)
            r_drain <= DRN_W'(DRAIN_CYC - 1);
         else if (r_state == DRAIN && r_drain != '0)
            r_drain <= r_drain - DRN_W'(1);
      end
   end

   lgc_sincos_lut #(.COS_W(COS_W)) u_lut (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_accept),
      .i_idx (r_phase[PHASE_W-1 -: LUT_AW]),
      .o_sin (w_sin),
      .o_cos (w_cos)
   );

   // Stage 1 delays the samples alongside the LUT register; stage 2 multiplies
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x_in  <= '0;
         r_x_out <= '0;
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         for (int k = 0; k < 4; k++) r_prod[k] <= '0;
      end else begin
         r_v1 <= w_accept;
         r_v2 <= r_v1;
         if (w_accept) begin
            r_x_in  <= i_s_in;
            r_x_out <= i_s_out;
         end
         if (r_v1) begin
            r_prod[0] <= PROD_W'(r_x_in)  * PROD_W'(w_cos);
            r_prod[1] <= PROD_W'(r_x_in)  * PROD_W'(w_sin);
            r_prod[2] <= PROD_W'(r_x_out) * PROD_W'(w_cos);
            r_prod[3] <= PROD_W'(r_x_out) * PROD_W'(w_sin);
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 4; k++) w_sat[k] = sat_add(r_acc[k], r_prod[k]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) r_acc[k] <= '0;
         r_ovf <= 1'b0;
      end else if (w_launch) begin
         for (int k = 0; k < 4; k++) r_acc[k] <= '0;
         r_ovf <= 1'b0;
      end else if (r_v2) begin
         for (int k = 0; k < 4; k++) r_acc[k] <= w_sat[k][ACC_W-1:0];
         r_ovf <= r_ovf | w_sat[0][ACC_W] | w_sat[1][ACC_W] | w_sat[2][ACC_W] | w_sat[3][ACC_W];
      end
   end

   assign o_r_in_i   = r_acc[0];
   assign o_r_in_q   = r_acc[1];
   assign o_r_out_i  = r_acc[2];
   assign o_r_out_q  = r_acc[3];
   assign o_overflow = r_ovf;

endmodule

// File: tb/tb_loop_gain_correlator.sv
// Bench for loop_gain_correlator: a 48-bit and a 24-bit accumulator build share stimulus,
// and results are compared with a real-valued sine/saturating-sum reference.
module tb_loop_gain_correlator;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               i_start;
   logic [23:0]        i_ftw;
   logic [15:0]        i_n_samples;
   logic               i_s_valid;
   logic signed [15:0] i_s_in;
   logic signed [15:0] i_s_out;
   logic               i_r_ready;
   logic               o_busy, o_r_valid, o_overflow;
   logic signed [47:0] o_r_in_i, o_r_in_q, o_r_out_i, o_r_out_q;
   logic               t_busy, t_r_valid, t_overflow;
   logic signed [23:0] t_r_in_i, t_r_in_q, t_r_out_i, t_r_out_q;

   int     n_chk;
   int     n_err;
   int     q_in[$];
   int     q_out[$];
   longint exp_v [2][4];
   bit     exp_ovf [2];

   always #5 clk = ~clk;

   loop_gain_correlator u_dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_ftw(i_ftw), .i_n_samples(i_n_samples),
      .i_s_valid(i_s_valid), .i_s_in(i_s_in), .i_s_out(i_s_out), .o_busy(o_busy),
      .o_r_valid(o_r_valid), .i_r_ready(i_r_ready), .o_r_in_i(o_r_in_i), .o_r_in_q(o_r_in_q),
      .o_r_out_i(o_r_out_i), .o_r_out_q(o_r_out_q), .o_overflow(o_overflow)
   );

   loop_gain_correlator #(.ACC_W(24)) u_dut24 (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_ftw(i_ftw), .i_n_samples(i_n_samples),
      .i_s_valid(i_s_valid), .i_s_in(i_s_in), .i_s_out(i_s_out), .o_busy(t_busy),
      .o_r_valid(t_r_valid), .i_r_ready(i_r_ready), .o_r_in_i(t_r_in_i), .o_r_in_q(t_r_in_q),
      .o_r_out_i(t_r_out_i), .o_r_out_q(t_r_out_q), .o_overflow(t_overflow)
   );

   task automatic chk_val(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint lut_model(input int p);
      real v;
      v = 2047.0 * $sin(2.0 * 3.14159265358979 * real'(p % 1024) / 1024.0);
      if (v >= 0.0) return longint'($floor(v + 0.5));
      return -longint'($floor(-v + 0.5));
   endfunction

   task automatic model_calc(input logic [23:0] ftw, input int n);
      longint hi, lo, c, s;
      longint acc [4];
      longint prod [4];
      logic [23:0] ph;
      int w;
      for (int d = 0; d < 2; d++) begin
         w  = (d == 0) ? 48 : 24;
         hi = (64'sd1 <<< (w - 1)) - 1;
         lo = -hi - 1;
         ph = '0;
         exp_ovf[d] = 1'b0;
         for (int k = 0; k < 4; k++) acc[k] = 0;
         for (int i = 0; i < n; i++) begin
            s = lut_model(int'(ph[23:14]));
            c = lut_model(int'(ph[23:14]) + 256);
            prod[0] = longint'(q_in[i]) * c;
            prod[1] = longint'(q_in[i]) * s;
            prod[2] = longint'(q_out[i]) * c;
            prod[3] = longint'(q_out[i]) * s;
            for (int k = 0; k < 4; k++) begin
               acc[k] = acc[k] + prod[k];
               if (acc[k] > hi) begin acc[k] = hi; exp_ovf[d] = 1'b1; end
               if (acc[k] < lo) begin acc[k] = lo; exp_ovf[d] = 1'b1; end
            end
            ph = ph + ftw;
         end
         for (int k = 0; k < 4; k++) exp_v[d][k] = acc[k];
      end
   endtask

   task automatic check_results(input string tag);
      chk_val({tag, "_in_i"},    o_r_in_i,   exp_v[0][0]);
      chk_val({tag, "_in_q"},    o_r_in_q,   exp_v[0][1]);
      chk_val({tag, "_out_i"},   o_r_out_i,  exp_v[0][2]);
      chk_val({tag, "_out_q"},   o_r_out_q,  exp_v[0][3]);
      chk_val({tag, "_ovf"},     o_overflow, longint'(exp_ovf[0]));
      chk_val({tag, "_in_i24"},  t_r_in_i,   exp_v[1][0]);
      chk_val({tag, "_in_q24"},  t_r_in_q,   exp_v[1][1]);
      chk_val({tag, "_out_i24"}, t_r_out_i,  exp_v[1][2]);
      chk_val({tag, "_out_q24"}, t_r_out_q,  exp_v[1][3]);
      chk_val({tag, "_ovf24"},   t_overflow, longint'(exp_ovf[1]));
   endtask

   task automatic fill_const(input int a, input int b, input int n);
      q_in.delete();
      q_out.delete();
      for (int i = 0; i < n; i++) begin q_in.push_back(a); q_out.push_back(b); end
   endtask

   task automatic fill_rand(input int n);
      q_in.delete();
      q_out.delete();
      for (int i = 0; i < n; i++) begin
         q_in.push_back(int'($urandom_range(65535)) - 32768);
         q_out.push_back(int'($urandom_range(65535)) - 32768);
      end
   endtask

   task automatic run_meas(input string tag, input logic [23:0] ftw, input int n,
                           input int max_gap, input int hold_cyc);
      int lat;
      model_calc(ftw, n);
      i_r_ready = (hold_cyc == 0);
      @(negedge clk);
      i_start = 1'b1; i_ftw = ftw; i_n_samples = 16'(n);
      @(negedge clk);
      i_start = 1'b0; i_ftw = 24'($urandom); i_n_samples = 16'($urandom);
      chk_val({tag, "_busy"}, o_busy, 1);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(max_gap, 0)) begin
            i_s_valid = 1'b0; i_s_in = 16'($urandom); i_s_out = 16'($urandom);
            @(negedge clk);
         end
         i_s_valid = 1'b1; i_s_in = 16'(q_in[i]); i_s_out = 16'(q_out[i]);
         @(negedge clk);
      end
      i_s_valid = 1'b0;
      lat = 1;
      while (o_r_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk_val({tag, "_lat"}, lat, 4);
      chk_val({tag, "_rv24"}, t_r_valid, 1);
      check_results(tag);
      for (int h = 0; h < hold_cyc; h++) begin
         i_start = 1'b1; i_n_samples = 16'd5; i_s_valid = 1'b1; i_s_in = 16'($urandom);
         @(negedge clk);
         chk_val({tag, "_hold_rv"}, o_r_valid, 1);
         chk_val({tag, "_hold_busy"}, o_busy, 1);
         chk_val({tag, "_hold_in_i"}, o_r_in_i, exp_v[0][0]);
         chk_val({tag, "_hold_out_q"}, o_r_out_q, exp_v[0][3]);
      end
      i_start = 1'b0; i_s_valid = 1'b0; i_r_ready = 1'b1;
      @(negedge clk);
      chk_val({tag, "_rv_drop"}, o_r_valid, 0);
      chk_val({tag, "_idle"}, o_busy, 0);
      chk_val({tag, "_persist"}, o_r_out_i, exp_v[0][2]);
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      rst_n = 1'b0; i_start = 1'b0; i_ftw = '0; i_n_samples = '0;
      i_s_valid = 1'b0; i_s_in = '0; i_s_out = '0; i_r_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_val("rst_busy", o_busy, 0);
      chk_val("rst_rvalid", o_r_valid, 0);
      chk_val("rst_in_i", o_r_in_i, 0);
      chk_val("rst_out_q", o_r_out_q, 0);
      chk_val("rst_ovf", o_overflow, 0);
      rst_n = 1'b1;
      @(negedge clk);

      i_start = 1'b1; i_n_samples = 16'd0;
      @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
      chk_val("zero_n_busy", o_busy, 0);

      fill_const(1000, 500, 8);
      run_meas("t1", 24'd0, 8, 0, 0);
      chk_val("t1_k_in_i", o_r_in_i, 16376000);
      chk_val("t1_k_out_i", o_r_out_i, 8188000);
      chk_val("t1_k_in_q", o_r_in_q, 0);
      chk_val("t1_k_out_q", o_r_out_q, 0);

      q_in = '{1000, 0, -1000, 0};
      q_out = '{0, -300, 0, 300};
      run_meas("t2", 24'h400000, 4, 0, 0);
      chk_val("t2_k_in_i", o_r_in_i, 4094000);
      chk_val("t2_k_in_q", o_r_in_q, 0);
      chk_val("t2_k_out_i", o_r_out_i, 0);
      chk_val("t2_k_out_q", o_r_out_q, -1228200);

      fill_const(1000, 500, 8);
      run_meas("t3", 24'd0, 8, 5, 0);
      chk_val("t3_k_in_i", o_r_in_i, 16376000);
      chk_val("t3_k_out_i", o_r_out_i, 8188000);

      fill_rand(6);
      run_meas("t4", 24'($urandom), 6, 2, 10);

      @(negedge clk);
      i_start = 1'b1; i_ftw = '0; i_n_samples = 16'd8;
      @(negedge clk);
      i_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         i_s_valid = 1'b1; i_s_in = 16'sd1000; i_s_out = 16'sd500;
         @(negedge clk);
      end
      i_s_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_val("t5_busy", o_busy, 0);
      chk_val("t5_rvalid", o_r_valid, 0);
      chk_val("t5_in_i", o_r_in_i, 0);
      chk_val("t5_out_i", o_r_out_i, 0);
      chk_val("t5_in_i24", t_r_in_i, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk_val("t5_no_result", o_r_valid, 0);
      chk_val("t5_still_idle", o_busy, 0);
      fill_const(1000, 500, 8);
      run_meas("t5", 24'd0, 8, 0, 0);
      chk_val("t5_k_in_i", o_r_in_i, 16376000);

      fill_const(32767, 0, 2);
      run_meas("t6", 24'd0, 2, 0, 0);
      chk_val("t6_k_sat24", t_r_in_i, 8388607);
      chk_val("t6_k_ovf24", t_overflow, 1);
      fill_const(10, -10, 3);
      run_meas("t6b", 24'd0, 3, 0, 0);
      chk_val("t6b_k_ovf24_clr", t_overflow, 0);

      for (int r = 0; r < 8; r++) begin
         fill_rand(int'($urandom_range(40, 1)));
         run_meas("rnd", 24'($urandom), q_in.size(), 3, int'($urandom_range(3, 0)));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/loop_gain_correlator.md
Name: loop_gain_correlator

Overview:
Digital lock-in receiver for loop-gain/stability measurement. It sits at the far end of an injected-tone measurement chain, opposite the tone generator that drives the AC injection source. It takes synchronously sampled injection-node (s_in) and response-node (s_out) voltages and correlates each against an internal NCO cos/sin. It returns I/Q sums for both channels, from which software forms gain = |out|/|in| and phase difference.

Parameters:
DATA_W, 16, signed sample width of s_in/s_out
PHASE_W, 24, NCO phase accumulator width
COS_W, 12, signed sin/cos LUT output width (amplitude 2^(COS_W-1)-1 = 2047)
CNT_W, 16, sample-count width
ACC_W, 48, signed accumulator/result width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin measurement (honoured only in IDLE)
ftw  in  PHASE_W  NCO frequency tuning word, latched on start
n_samples  in  CNT_W  samples per measurement, latched on start
s_valid  in  1  sample strobe
s_in  in  DATA_W  injection-node sample, signed
s_out  in  DATA_W  response-node sample, signed
busy  out  1  high when not IDLE
r_valid  out  1  result valid
r_ready  in  1  result consumed
r_in_i, r_in_q, r_out_i, r_out_q  out  ACC_W each  signed sums: x·cos (I), x·sin (Q)
overflow  out  1  sticky saturation flag for the current result

Behaviour:
- Reset (async assert, sync deassert): state IDLE. All outputs 0, accumulators 0, phase 0, count 0.
- States: IDLE, ACCUM, DRAIN, HOLD.
- IDLE:
  - start=1 with n_samples≠0: latch ftw and n_samples; clear phase, count, accumulators and overflow; go to ACCUM. busy=1 from the next cycle.
  - start with n_samples=0 is ignored.
- ACCUM, on each cycle with s_valid=1:
  - LUT index = phase[PHASE_W-1 -: 10].
  - Sample products x·cos and x·sin feed the pipeline.
  - phase += ftw, modulo 2^PHASE_W (wraps silently).
  - count++.
  - Cycles with s_valid=0 do nothing. The result is independent of gap pattern.
  - When the n_samples-th sample is accepted, go to DRAIN.
- Pipeline: stage 1 registered LUT plus sample delay; stage 2 registered multiply (DATA_W+COS_W bits); stage 3 accumulate. DRAIN lasts exactly 3 cycles.
- HOLD is entered after DRAIN; r_valid=1 in the first HOLD cycle. Last-sample-accept edge to r_valid high is 4 cycles.
- HOLD: results and overflow are held stable until r_valid&&r_ready, then IDLE, with r_valid=0 and busy=0 next cycle. Results remain on the ports after leaving HOLD until the next start.
- start is ignored in ACCUM, DRAIN and HOLD. s_valid is ignored outside ACCUM.
- LUT: quarter-wave, 10-bit phase index, value = round(2047·sin(2π·p/1024)). Exact values: 0 at p=0/512, ±2047 at p=256/768. cos(p) = sin(p+256).
- Accumulation is saturating at ±(2^(ACC_W-1)) bounds. Any saturation of any of the 4 sums sets overflow=1, which stays set until the next start.
- rst_n asserted mid-measurement aborts everything immediately; no result is produced.

Decomposition:
- Package lgc_pkg: state enum (IDLE/ACCUM/DRAIN/HOLD), LUT_AW=10, LUT amplitude constant, DRAIN_CYC=3.
- Sub-module lgc_sincos_lut: quarter-wave ROM with quadrant folding; registered sin/cos output, 1-cycle latency.
- Top level holds the FSM, NCO, multipliers and saturating accumulators.

Test Plan:
1. ftw=0, n_samples=8, s_in=1000, s_out=500, back-to-back s_valid, r_ready=1 → r_in_i=16,376,000, r_out_i=8,188,000, both Q=0, overflow=0; r_valid 4 cycles after the 8th sample, one cycle long.
2. ftw=2^22 (period 4), n=4, s_in=1000,0,-1000,0, s_out=0,-300,0,300 → r_in_i=4,094,000, r_in_q=0, r_out_i=0, r_out_q=-1,228,200.
3. Repeat test 1 with random 0–5 cycle s_valid gaps → identical results.
4. r_ready=0 for 10 cycles in HOLD, pulse start and s_valid meanwhile → results unchanged, r_valid held, busy=1, no new measurement; release r_ready → IDLE next cycle.
5. Assert rst_n=0 after 3 of 8 samples → all outputs 0 asynchronously; a new start with test-1 stimulus yields the test-1 results.
6. ACC_W=24 build, ftw=0, n=2, s_in=32767 → r_in_i=8,388,607 (saturated), overflow=1; next start clears overflow.
